branch_predicting_pc_unit: RTL

Fetch-stage program counter with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters. It replaces the fixed "predict not-taken, flush on taken" scheme. It predicts the next fetch PC in IF and accepts branch resolution from EX. It raises a mispredict/redirect when the prediction was wrong, trains the predictor, and keeps branch statistics plus the sticky end-of-program flag.

---
 rtl/branch_predicting_pc_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/branch_predicting_pc_unit.sv
// -----------------------------------------------------------------------------
// branch_predicting_pc_unit
//
// Fetch-stage program counter with a direct-mapped branch target buffer and
// 2-bit saturating direction counters. IF gets a combinational prediction for
// the current fetch address. EX reports each resolved conditional branch back
// to this unit. When the prediction made for that branch was wrong, the unit
// raises a redirect, and it trains the predictor on every resolved branch. The
// unit also keeps saturating branch/mispredict statistics and the sticky
// end-of-program flag.
//
// Ports
//   clk                 clock
//   rstn                synchronous active-low reset
//   core_start          0 holds the unit in its reset state (statistics kept)
//   stall               load-use stall; hold the fetch PC
//   pc_if               current fetch address
//   pred_taken_if       predicted direction for pc_if
//   pred_target_if      predicted next fetch address when pc_if is a taken branch
//   resolve_valid       EX holds a resolved conditional branch this cycle
//   resolve_pc          PC of that branch
//   resolve_taken       actual outcome
//   resolve_target      actual taken target
//   resolve_pred_taken  direction that was predicted for that branch
//   resolve_pred_target target that was predicted for that branch
//   mispredict          combinational redirect / flush request
//   branch_count        resolved branches, saturating
//   mispredict_count    mispredicted branches, saturating
//   core_end            sticky end-of-program flag
// -----------------------------------------------------------------------------
module branch_predicting_pc_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     BTB_ENTRIES = 64,
  parameter logic [XLEN-1:0] END_PC      = 44,
  parameter int unsigned     CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             core_start,
  input  logic             stall,
  output logic [XLEN-1:0]  pc_if,
  output logic             pred_taken_if,
  output logic [XLEN-1:0]  pred_target_if,
  input  logic             resolve_valid,
  input  logic [XLEN-1:0]  resolve_pc,
  input  logic             resolve_taken,
  input  logic [XLEN-1:0]  resolve_target,
  input  logic             resolve_pred_taken,
  input  logic [XLEN-1:0]  resolve_pred_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic             core_end
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  localparam logic [1:0] CTR_INIT  = 2'b01;  // weakly not-taken
  localparam logic [1:0] CTR_ALLOC = 2'b10;  // weakly taken

  // BTB storage
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];

  // Fetch-side state
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             core_end_q, core_end_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  logic in_reset;
  assign in_reset = !rstn || !core_start;

  // ---------------------------------------------------------------------------
  // Lookup for the current fetch address
  // ---------------------------------------------------------------------------
  logic [IDX-1:0]   if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [XLEN-1:0]  pc_plus4;

  assign if_idx   = pc_q[IDX+1:2];
  assign if_tag   = pc_q[XLEN-1:IDX+2];
  assign if_hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pc_plus4 = pc_q + XLEN'(4);

  assign pc_if          = pc_q;
  assign pred_taken_if  = if_hit && ctr_q[if_idx][1];
  assign pred_target_if = if_hit ? target_q[if_idx] : pc_plus4;

  // ---------------------------------------------------------------------------
  // Resolution from EX
  // ---------------------------------------------------------------------------
  logic [IDX-1:0]   rs_idx;
  logic [TAG_W-1:0] rs_tag;
  logic             rs_hit;

  assign rs_idx = resolve_pc[IDX+1:2];
  assign rs_tag = resolve_pc[XLEN-1:IDX+2];
  assign rs_hit = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);

  // A correct "taken" prediction still needs the right target to count.
  assign mispredict = resolve_valid &&
                      ((resolve_taken != resolve_pred_taken) ||
                       (resolve_taken && (resolve_target != resolve_pred_target)));

  // Training controls. A reset in the same cycle suppresses the write.
  logic       train_en;
  logic       tgt_we;   // allocate or refresh the entry (taken branches)
  logic       ctr_we;
  logic [1:0] ctr_wr;

  assign train_en = resolve_valid && !in_reset;
  assign tgt_we   = train_en && resolve_taken;
  assign ctr_we   = train_en && (resolve_taken || rs_hit);

  // NOTE: every variable assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    ctr_wr = ctr_q[rs_idx];
    if (resolve_taken) begin
      if (!rs_hit)                      ctr_wr = CTR_ALLOC;
      else if (ctr_q[rs_idx] != 2'b11)  ctr_wr = ctr_q[rs_idx] + 2'b01;
    end else if (rs_hit && (ctr_q[rs_idx] != 2'b00)) begin
      ctr_wr = ctr_q[rs_idx] - 2'b01;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d = pc_plus4;
    if (in_reset)           pc_d = RESET_PC;
    else if (mispredict)    pc_d = resolve_taken ? resolve_target : resolve_pc + XLEN'(4);
    else if (stall)         pc_d = pc_q;
    else if (pred_taken_if) pc_d = pred_target_if;
  end

  always_comb begin
    core_end_d = core_end_q;
    if (in_reset)
      core_end_d = 1'b0;
    else if ((pc_q == END_PC) && !stall && !mispredict)
      core_end_d = 1'b1;
  end

  // Statistics survive core_start=0; only rstn clears them.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (!rstn) begin
      branch_count_d     = '0;
      mispredict_count_d = '0;
    end else if (train_en) begin
      if (branch_count_q != {CNT_W{1'b1}})
        branch_count_d = branch_count_q + CNT_W'(1);
      if (mispredict && (mispredict_count_q != {CNT_W{1'b1}}))
        mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    pc_q               <= pc_d;
    core_end_q         <= core_end_d;
    branch_count_q     <= branch_count_d;
    mispredict_count_q <= mispredict_count_d;
  end

  // NOTE: only valid bits and counters are reset. Tags and targets are
  // meaningless while valid=0, so that storage is left without a reset and can
  // map onto plain RAM.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else begin
      if (tgt_we) valid_q[rs_idx] <= 1'b1;
      if (ctr_we) ctr_q[rs_idx]   <= ctr_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (tgt_we) begin
      tag_q[rs_idx]    <= rs_tag;
      target_q[rs_idx] <= resolve_target;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
  assign core_end         = core_end_q;

  // Instructions are word aligned; the byte-offset bits carry no information.
  logic unused_lsbs;
  assign unused_lsbs = ^{pc_q[1:0], resolve_pc[1:0]};

endmodule
